// File: rtl/capture_trigger_ctrl.sv
// capture_trigger_ctrl
//   Logic-analyser capture controller for the 8-channel input sampler. Samples
//   the live channel inputs at a divided rate into a circular buffer, waits for
//   a masked pattern trigger, captures the post-trigger window, and streams the
//   DEPTH-sample record out oldest-first over a valid/ready port.
// Ports
//   clk, reset        clock; synchronous active-high reset
//   i_sample_in       live channel inputs
//   i_arm / i_abort   start capture (IDLE/DONE only) / return to IDLE
//   i_trig_mask       1 = channel participates in the trigger
//   i_trig_value      required level of participating channels
//   i_pre_cnt         pre-trigger samples to keep (clamped to DEPTH-1)
//   i_div             sample tick every div+1 clocks
//   o_rd_data         buffer word at read pointer (0 when not valid)
//   o_rd_valid        o_rd_data valid
//   i_rd_ready        consumer accepts word
//   o_rd_last         final word of the record
//   o_busy            capture or readout in progress
//   o_triggered       trigger seen this capture
//   o_done            record fully read
module capture_trigger_ctrl #(
  parameter int NUM_CH = 8,
  parameter int DEPTH  = 10,
  parameter int DIV_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        i_sample_in,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic [NUM_CH-1:0]        i_trig_mask,
  input  logic [NUM_CH-1:0]        i_trig_value,
  input  logic [$clog2(DEPTH)-1:0] i_pre_cnt,
  input  logic [DIV_W-1:0]         i_div,
  output logic [NUM_CH-1:0]        o_rd_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic                     o_rd_last,
  output logic                     o_busy,
  output logic                     o_triggered,
  output logic                     o_done
);

  localparam int PTR_W = $clog2(DEPTH);
  // The counter must reach DEPTH (post window with no pre-trigger samples).
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_POST    = 3'd3;
  localparam logic [2:0] S_READOUT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        r_state;
  logic [NUM_CH-1:0] r_mask;
  logic [NUM_CH-1:0] r_value;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [PTR_W-1:0]  r_pre;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_triggered;
  logic [NUM_CH-1:0] r_mem [DEPTH];

  logic              w_active;
  logic              w_tick;
  logic              w_match;
  logic              w_arm_ok;
  logic [PTR_W-1:0]  w_pre_clamp;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_pre_ext;
  logic [CNT_W-1:0]  w_post_end;

  function automatic logic [PTR_W-1:0] f_wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_active    = (r_state == S_FILL) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_tick      = w_active && (r_div_cnt == r_div);
  assign w_match     = ((i_sample_in ^ r_value) & r_mask) == '0;
  assign w_arm_ok    = i_arm && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_pre_clamp = (i_pre_cnt > LAST_PTR) ? LAST_PTR : i_pre_cnt;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_pre_ext   = CNT_W'(r_pre);
  // Post window ends once pre + trigger + post samples fill the record.
  assign w_post_end  = DEPTH_C - w_pre_ext;

  // Buffer contents are never reset; only the pointers are.
  always_ff @(posedge clk) begin
    if (!reset && !i_abort && w_tick) r_mem[r_wptr] <= i_sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_value     <= '0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_pre       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_triggered <= 1'b0;
    end else if (w_arm_ok) begin
      r_mask      <= i_trig_mask;
      r_value     <= i_trig_value;
      r_div       <= i_div;
      r_pre       <= w_pre_clamp;
      r_div_cnt   <= '0;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_triggered <= 1'b0;
      r_state     <= (w_pre_clamp == '0) ? S_WAIT : S_FILL;
    end else begin
      if (w_active) r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick)   r_wptr    <= f_wrap_inc(r_wptr);
      case (r_state)
        S_FILL: begin
          if (w_tick) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_pre_ext) r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_tick && w_match) begin
            r_triggered <= 1'b1;
            // With a full pre-trigger window the trigger sample completes the record.
            if (r_pre == LAST_PTR) begin
              r_state <= S_READOUT;
              r_rptr  <= f_wrap_inc(r_wptr);
              r_cnt   <= '0;
            end else begin
              r_state <= S_POST;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        S_POST: begin
          if (w_tick) begin
            if (w_cnt_inc == w_post_end) begin
              r_state <= S_READOUT;
              // Oldest sample sits just past the last write.
              r_rptr  <= f_wrap_inc(r_wptr);
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        S_READOUT: begin
          if (i_rd_ready) begin
            r_rptr <= f_wrap_inc(r_rptr);
            r_cnt  <= w_cnt_inc;
            if (r_cnt == LAST_CNT) r_state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rd_valid  = (r_state == S_READOUT);
  assign o_rd_data   = o_rd_valid ? r_mem[r_rptr] : '0;
  assign o_rd_last   = o_rd_valid && (r_cnt == LAST_CNT);
  assign o_busy      = w_active || (r_state == S_READOUT);
  assign o_triggered = r_triggered;
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// tb_capture_trigger_ctrl
//   Scoreboard bench for capture_trigger_ctrl. Each directed capture pushes its
//   hand-computed record into a queue; a monitor pops and compares every word
//   the DUT presents, including the last-word flag and stall stability.
module tb_capture_trigger_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample_in = '0;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] trig_mask = '0;
  logic [7:0] trig_value = '0;
  logic [3:0] pre_cnt = '0;
  logic [7:0] div = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       rd_last;
  logic       busy;
  logic       triggered;
  logic       done;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  capture_trigger_ctrl #(.NUM_CH(8), .DEPTH(10), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .i_sample_in(sample_in), .i_arm(arm), .i_abort(abort),
    .i_trig_mask(trig_mask), .i_trig_value(trig_value), .i_pre_cnt(pre_cnt), .i_div(div),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_last(rd_last),
    .o_busy(busy), .o_triggered(triggered), .o_done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every presented word must match the queue head (also while stalled).
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {23'd0, rd_last, rd_data}, 32'h1ff);
      end else begin
        chk("rd_data", {24'd0, rd_data}, {24'd0, exp_q[0][7:0]});
        chk("rd_last", {31'd0, rd_last}, {31'd0, exp_q[0][8]});
        if (rd_ready) begin
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end
  end

  task automatic push_rec(input logic [7:0] w [10]);
    for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), w[i]});
    hs_count = 0;
  endtask

  task automatic do_arm(input logic [7:0] m, input logic [7:0] v,
                        input logic [3:0] p, input logic [7:0] d);
    trig_mask = m; trig_value = v; pre_cnt = p; div = d; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic drive(input logic [7:0] s);
    sample_in = s;
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rnd, input string tag);
    int n;
    n = 0;
    while (!done && n < 300) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    rd_ready = 1'b0;
    chk({tag, "_done_within_budget"}, {31'd0, (n < 300)}, 32'd1);
    chk({tag, "_handshakes"}, hs_count, 32'd10);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_clear"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rec [10];

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_outputs", {20'd0, rd_data, rd_valid, rd_last, busy, triggered},  32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    // T1: reset while in the post-trigger window
    do_arm(8'h01, 8'h01, 4'd2, 8'd0);
    drive(8'h00); drive(8'h00); drive(8'h01); drive(8'h02);
    chk("t1_triggered", {31'd0, triggered}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t1_after_reset", {20'd0, rd_data, rd_valid, rd_last, busy, triggered}, 32'd0);
    chk("t1_done", {31'd0, done}, 32'd0);

    // T2: pre=3, trigger on bit0 high
    rec = '{8'h16, 8'h18, 8'h1A, 8'h1B, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    push_rec(rec);
    do_arm(8'h01, 8'h01, 4'd3, 8'd0);
    drive(8'h10); drive(8'h12); drive(8'h14); drive(8'h16); drive(8'h18); drive(8'h1A);
    chk("t2_not_yet_triggered", {31'd0, triggered}, 32'd0);
    drive(8'h1B);
    chk("t2_triggered", {31'd0, triggered}, 32'd1);
    for (int k = 0; k < 6; k++) drive(8'h20 + 8'(k));
    chk("t2_readout_valid", {31'd0, rd_valid}, 32'd1);
    drain(1'b0, "t2");
    chk("t2_triggered_kept", {31'd0, triggered}, 32'd1);

    // T3/T5: mask=0 pre=0 from DONE, random stalls during readout
    for (int k = 0; k < 10; k++) rec[k] = 8'hA0 + 8'(k);
    push_rec(rec);
    do_arm(8'h00, 8'h00, 4'd0, 8'd0);
    chk("t3_arm_from_done", {30'd0, busy, done}, 32'd2);
    chk("t3_trig_cleared", {31'd0, triggered}, 32'd0);
    for (int k = 0; k < 10; k++) drive(8'hA0 + 8'(k));
    drain(1'b1, "t3");

    // pre_cnt above DEPTH-1 clamps to 9: trigger sample is the last word
    rec = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'h3C};
    push_rec(rec);
    do_arm(8'hFF, 8'h3C, 4'd15, 8'd0);
    for (int k = 0; k < 10; k++) drive(8'hC0 + 8'(k));
    chk("clamp_waiting", {31'd0, rd_valid}, 32'd0);
    drive(8'h3C);
    chk("clamp_readout_now", {31'd0, rd_valid}, 32'd1);
    drain(1'b0, "clamp");

    // T4: div=3 -> one write every 4 clocks; record reveals which clocks sampled
    for (int k = 0; k < 10; k++) rec[k] = 8'h43 + 8'(4 * k);
    push_rec(rec);
    do_arm(8'h00, 8'h00, 4'd0, 8'd3);
    for (int k = 0; k < 40; k++) begin
      if (k == 39) chk("t4_not_early", {31'd0, rd_valid}, 32'd0);
      drive(8'h40 + 8'(k));
    end
    chk("t4_readout_at_40", {31'd0, rd_valid}, 32'd1);
    drain(1'b1, "t4");

    // T6: arm while busy ignored; abort+arm together returns to IDLE
    do_arm(8'hFF, 8'h55, 4'd1, 8'd0);
    drive(8'h00);
    do_arm(8'h00, 8'h00, 4'd0, 8'd0);
    drive(8'h00); drive(8'h00);
    chk("t6_arm_ignored", {30'd0, busy, triggered}, 32'd2);
    abort = 1'b1; arm = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; arm = 1'b0;
    chk("t6_abort_idle", {20'd0, rd_data, rd_valid, rd_last, busy, triggered}, 32'd0);
    chk("t6_abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t6_still_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
